apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single APB master bridge (APB_protocol) between NUM_REQ requesters. It accepts one read or write request at a time and drives the bridge's transfer/read_write/address/data inputs for a fixed access window. It then captures read data and returns a per-requester response pulse. It sits between local requesters (CPU stub, DMA, config engine) and the bridge, which selects one of two slaves with address bit 8.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 9, APB address width; MSB is the slave select
DATA_W, 8, APB data width
HOLD_CYCLES, 2, cycles transfer is held high per access (>=2)
GAP_CYCLES, 1, idle cycles inserted after each access (>=0)

Ports:
pclk  in  1  clock
preset  in  1  asynchronous active-low reset
req  in  NUM_REQ  request level per requester
req_rw  in  NUM_REQ  per requester: 1 = read, 0 = write
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data; same packing
gnt  out  NUM_REQ  one-hot, one-cycle pulse: request accepted
rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: access complete
rsp_rdata  out  DATA_W  read data; valid with rsp_valid
busy  out  1  high whenever state != IDLE
transfer  out  1  to bridge
read_write  out  1  to bridge; 1 = read
apb_read_paddr  out  ADDR_W  to bridge
apb_write_paddr  out  ADDR_W  to bridge
apb_write_data  out  DATA_W  to bridge
apb_read_dataout  in  DATA_W  from bridge

Behaviour:
- Reset (preset=0, async): state=IDLE, rr pointer=0. All outputs are 0: gnt, rsp_valid, rsp_rdata, busy, transfer, read_write, both addresses, write data. A reset mid-access aborts the access immediately. The aborted owner gets no rsp_valid.
- All outputs are registered.
- FSM states: IDLE, XFER, DONE, GAP.
- IDLE: at a rising edge with any req bit set, select winner i = first set bit searching from the pointer upward with wrap. Then:
  - gnt[i]=1 for exactly one cycle.
  - transfer=1 and read_write=req_rw[i].
  - On a read, apb_read_paddr=req_addr[i] and apb_write_paddr=0.
  - On a write, apb_write_paddr=req_addr[i] and apb_write_data=req_wdata[i].
  - Unused address/data outputs are held at 0.
  - pointer=(i+1) mod NUM_REQ.
  - Go to XFER.
- With no req set, stay in IDLE.
- XFER: request fields are latched; later changes on the req_* inputs are ignored. Hold transfer=1 for exactly HOLD_CYCLES cycles, counted by an internal counter. At the edge ending the last XFER cycle:
  - transfer=0.
  - rsp_valid[i]=1.
  - rsp_rdata = apb_read_dataout on a read, 0 on a write.
  - Go to DONE.
- DONE: one cycle. Address/data outputs keep their values. rsp_valid clears at the next edge. Next state is GAP if GAP_CYCLES>0, else IDLE.
- GAP: GAP_CYCLES cycles with transfer=0, then go to IDLE.
- Request handshake:
  - A requester keeps req, rw, addr and wdata stable until it sees gnt.
  - It drops req in the cycle after gnt unless it wants another access.
  - A req still high when the FSM re-enters IDLE counts as a new request.
- Timing:
  - Latency from gnt to rsp_valid = HOLD_CYCLES cycles.
  - Minimum gnt-to-gnt spacing = HOLD_CYCLES+GAP_CYCLES+2 cycles (5 at defaults).
- Simultaneous requests are resolved by the round-robin rule only. Under sustained load each active requester is served once per NUM_REQ grants.
- Requester index counter and pointer are $clog2(NUM_REQ) bits wide; wrap is explicit for non-power-of-2 NUM_REQ.

Optional Feature:
APB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest set req index always wins, and the pointer logic is removed.
- Undefined: round-robin as above.
- All handshake and timing rules are identical in both builds.

Test Plan:
1. Reset, then req[0] write addr=5 data=69 -> gnt[0] pulse; transfer high for 2 cycles with apb_write_paddr=5, apb_write_data=69, read_write=0; rsp_valid[0] 2 cycles after gnt; rsp_rdata=0.
2. req[1] write 269/121, then req[2] read 269 -> apb_read_paddr=269, apb_write_paddr=0; rsp_valid[2] with rsp_rdata=121 (slave 2 path).
3. All four req high continuously, pointer=0 -> grant order 0,1,2,3,0; gnt-to-gnt spacing exactly 5 cycles; exactly one gnt bit ever set.
4. req[3] alone, then req[0] and req[3] together -> req[0] granted first (pointer wrapped to 0), then req[3]. With APB_ARB_FIXED_PRIO_EN and req[0] held high, req[3] is never granted.
5. Assert preset=0 during the second XFER cycle of a write to addr 10 -> transfer, busy and gnt drop to 0 immediately; no rsp_valid; after release, the first grant goes to the lowest pending index.
6. Change req_addr[0] from 5 to 310 during XFER -> bridge address stays 5 until the access completes.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// Round-robin request arbiter/sequencer in front of a single APB master bridge.
// Optional build macro APB_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module apb_req_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic                        pclk,
  input  logic                        preset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        busy,
  output logic                        transfer,
  output logic                        read_write,
  output logic [ADDR_W-1:0]           apb_read_paddr,
  output logic [ADDR_W-1:0]           apb_write_paddr,
  output logic [DATA_W-1:0]           apb_write_data,
  input  logic [DATA_W-1:0]           apb_read_dataout
);

  localparam int unsigned IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_MAX   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned HOLD_LAST = HOLD_CYCLES - 1;
  localparam int unsigned GAP_LAST  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, XFER, DONE, GAP} state_t;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [IDX_W-1:0]   owner_q, owner_n;
  logic [IDX_W-1:0]   base;

  logic [NUM_REQ-1:0] gnt_n, rsp_valid_n;
  logic [DATA_W-1:0]  rsp_rdata_n, apb_write_data_n;
  logic               busy_n, transfer_n, read_write_n;
  logic [ADDR_W-1:0]  apb_read_paddr_n, apb_write_paddr_n;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W:0]     cand;

`ifdef APB_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [IDX_W-1:0]   ptr_q, ptr_n;
  assign base = ptr_q;
`endif

  // Unpack the flat per-requester address/data buses.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  // First set request at or above the base index, wrapping explicitly.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, base} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!win_found && req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      owner_q         <= '0;
`ifndef APB_ARB_FIXED_PRIO_EN
      ptr_q           <= '0;
`endif
      gnt             <= '0;
      rsp_valid       <= '0;
      rsp_rdata       <= '0;
      busy            <= 1'b0;
      transfer        <= 1'b0;
      read_write      <= 1'b0;
      apb_read_paddr  <= '0;
      apb_write_paddr <= '0;
      apb_write_data  <= '0;
    end else begin
      state_q         <= state_n;
      cnt_q           <= cnt_n;
      owner_q         <= owner_n;
`ifndef APB_ARB_FIXED_PRIO_EN
      ptr_q           <= ptr_n;
`endif
      gnt             <= gnt_n;
      rsp_valid       <= rsp_valid_n;
      rsp_rdata       <= rsp_rdata_n;
      busy            <= busy_n;
      transfer        <= transfer_n;
      read_write      <= read_write_n;
      apb_read_paddr  <= apb_read_paddr_n;
      apb_write_paddr <= apb_write_paddr_n;
      apb_write_data  <= apb_write_data_n;
    end
  end

  always_comb begin
    state_n           = state_q;
    cnt_n             = cnt_q;
    owner_n           = owner_q;
`ifndef APB_ARB_FIXED_PRIO_EN
    ptr_n             = ptr_q;
`endif
    gnt_n             = '0;
    rsp_valid_n       = '0;
    rsp_rdata_n       = rsp_rdata;
    transfer_n        = transfer;
    read_write_n      = read_write;
    apb_read_paddr_n  = apb_read_paddr;
    apb_write_paddr_n = apb_write_paddr;
    apb_write_data_n  = apb_write_data;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_n[win_idx] = 1'b1;
          owner_n        = win_idx;
          transfer_n     = 1'b1;
          read_write_n   = req_rw[win_idx];
          if (req_rw[win_idx]) begin
            apb_read_paddr_n  = addr_arr[win_idx];
            apb_write_paddr_n = '0;
            apb_write_data_n  = '0;
          end else begin
            apb_read_paddr_n  = '0;
            apb_write_paddr_n = addr_arr[win_idx];
            apb_write_data_n  = wdata_arr[win_idx];
          end
`ifndef APB_ARB_FIXED_PRIO_EN
          ptr_n = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
`endif
          cnt_n   = '0;
          state_n = XFER;
        end
      end
      // Request fields live only in the output flops; inputs are ignored here.
      XFER: begin
        if (cnt_q == CNT_W'(HOLD_LAST)) begin
          transfer_n           = 1'b0;
          rsp_valid_n[owner_q] = 1'b1;
          rsp_rdata_n          = read_write ? apb_read_dataout : '0;
          state_n              = DONE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        read_write_n      = 1'b0;
        apb_read_paddr_n  = '0;
        apb_write_paddr_n = '0;
        apb_write_data_n  = '0;
        cnt_n             = '0;
        state_n           = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_LAST)) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed self-checking bench for apb_req_arbiter with a two-slave APB memory stub.
module tb_apb_req_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned DATA_W  = 8;

  logic                      pclk;
  logic                      preset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_rw;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      busy;
  logic                      transfer;
  logic                      read_write;
  logic [ADDR_W-1:0]         apb_read_paddr;
  logic [ADDR_W-1:0]         apb_write_paddr;
  logic [DATA_W-1:0]         apb_write_data;
  logic [DATA_W-1:0]         apb_read_dataout;

  int tests;
  int errors;
  int cyc;

  apb_req_arbiter dut (
    .pclk             (pclk),
    .preset           (preset),
    .req              (req),
    .req_rw           (req_rw),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .gnt              (gnt),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .busy             (busy),
    .transfer         (transfer),
    .read_write       (read_write),
    .apb_read_paddr   (apb_read_paddr),
    .apb_write_paddr  (apb_write_paddr),
    .apb_write_data   (apb_write_data),
    .apb_read_dataout (apb_read_dataout)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Bridge + slaves stand-in: address bit 8 selects the slave, so a flat 512-entry memory covers both.
  logic [DATA_W-1:0] mem [512];
  assign apb_read_dataout = mem[apb_read_paddr];
  always @(posedge pclk) if (transfer && !read_write) mem[apb_write_paddr] <= apb_write_data;

  initial cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic rw, input int addr, input int data);
    req_rw[i]                    = rw;
    req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    req_wdata[i*DATA_W +: DATA_W] = DATA_W'(data);
    req[i]                       = 1'b1;
  endtask

  task automatic wait_gnt(output int idx, output int stamp);
    bit seen = 1'b0;
    idx = -1;
    stamp = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      if (gnt != '0) begin
        seen = 1'b1;
        stamp = cyc;
        for (int b = 0; b < NUM_REQ; b++) if (gnt[b]) idx = b;
      end
    end
    if (!seen) check("gnt_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      if (!busy) seen = 1'b1;
    end
    if (!seen) check("idle_timeout", 32'(1), 32'(0));
  endtask

  int idx, stamp, prev_stamp;
  int exp_order [5];

  initial begin
    tests = 0;
    errors = 0;
    for (int a = 0; a < 512; a++) mem[a] = '0;
    preset    = 1'b0;
    req       = '0;
    req_rw    = '0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset state
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_transfer", 32'(transfer), 32'(0));
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_addrs", 32'({apb_read_paddr, apb_write_paddr, apb_write_data, rsp_rdata, read_write}), 32'(0));
    preset = 1'b1;
    tick();

    // 1: single write
    set_req(0, 1'b0, 5, 69);
    wait_gnt(idx, stamp);
    req[0] = 1'b0;
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_transfer", 32'(transfer), 32'(1));
    check("t1_rw", 32'(read_write), 32'(0));
    check("t1_wpaddr", 32'(apb_write_paddr), 32'(5));
    check("t1_wdata", 32'(apb_write_data), 32'(69));
    check("t1_rpaddr", 32'(apb_read_paddr), 32'(0));
    check("t1_busy", 32'(busy), 32'(1));
    tick();
    check("t1_gnt_pulse", 32'(gnt), 32'(0));
    check("t1_transfer_hold", 32'(transfer), 32'(1));
    check("t1_rsp_early", 32'(rsp_valid), 32'(0));
    tick();
    check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t1_transfer_off", 32'(transfer), 32'(0));
    check("t1_rdata", 32'(rsp_rdata), 32'(0));
    check("t1_done_addr", 32'(apb_write_paddr), 32'(5));
    tick();
    check("t1_rsp_clear", 32'(rsp_valid), 32'(0));
    check("t1_gap_busy", 32'(busy), 32'(1));
    tick();
    check("t1_idle", 32'(busy), 32'(0));

    // 2: write to slave 2 then read it back
    set_req(1, 1'b0, 269, 121);
    wait_gnt(idx, stamp);
    req[1] = 1'b0;
    check("t2_wr_idx", 32'(idx), 32'(1));
    check("t2_wpaddr", 32'(apb_write_paddr), 32'(269));
    wait_idle();
    set_req(2, 1'b1, 269, 0);
    wait_gnt(idx, stamp);
    req[2] = 1'b0;
    check("t2_rd_idx", 32'(idx), 32'(2));
    check("t2_rw", 32'(read_write), 32'(1));
    check("t2_rpaddr", 32'(apb_read_paddr), 32'(269));
    check("t2_wpaddr_zero", 32'(apb_write_paddr), 32'(0));
    tick();
    tick();
    check("t2_rsp_valid", 32'(rsp_valid), 32'h4);
    check("t2_rdata", 32'(rsp_rdata), 32'(121));
    wait_idle();

    // 4: pointer wrap (run before 3 so the pointer returns to 0)
    set_req(3, 1'b0, 20, 1);
    wait_gnt(idx, stamp);
    req[3] = 1'b0;
    check("t4_alone", 32'(idx), 32'(3));
    wait_idle();
    set_req(0, 1'b0, 21, 2);
    set_req(3, 1'b0, 22, 3);
    wait_gnt(idx, stamp);
    req[0] = 1'b0;
    check("t4_first", 32'(idx), 32'(0));
    wait_gnt(idx, stamp);
    req[3] = 1'b0;
    check("t4_second", 32'(idx), 32'(3));
    wait_idle();

    // 3: all requesters held high
`ifdef APB_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 30 + i, 40 + i);
    prev_stamp = 0;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(idx, stamp);
      check($sformatf("t3_order%0d", g), 32'(idx), 32'(exp_order[g]));
      check($sformatf("t3_onehot%0d", g), 32'($onehot(gnt)), 32'(1));
      if (g > 0) check($sformatf("t3_spacing%0d", g), 32'(stamp - prev_stamp), 32'(5));
      prev_stamp = stamp;
    end
    req = '0;
    wait_idle();

    // 5: reset during the second XFER cycle of a write
    set_req(0, 1'b0, 10, 55);
    wait_gnt(idx, stamp);
    req[0] = 1'b0;
    check("t5_idx", 32'(idx), 32'(0));
    tick();
    set_req(3, 1'b0, 50, 5);
    set_req(1, 1'b0, 51, 6);
    #1 preset = 1'b0;
    #1;
    check("t5_transfer", 32'(transfer), 32'(0));
    check("t5_busy", 32'(busy), 32'(0));
    check("t5_gnt", 32'(gnt), 32'(0));
    tick();
    check("t5_no_rsp", 32'(rsp_valid), 32'(0));
    preset = 1'b1;
    wait_gnt(idx, stamp);
    req[1] = 1'b0;
    check("t5_after_idx", 32'(idx), 32'(1));
    check("t5_after_rsp", 32'(rsp_valid), 32'(0));
    wait_gnt(idx, stamp);
    req[3] = 1'b0;
    check("t5_then_idx", 32'(idx), 32'(3));
    wait_idle();

    // 6: request fields latched at grant
    set_req(0, 1'b0, 5, 7);
    wait_gnt(idx, stamp);
    req[0] = 1'b0;
    req_addr[0 +: ADDR_W] = ADDR_W'(310);
    check("t6_addr_gnt", 32'(apb_write_paddr), 32'(5));
    tick();
    check("t6_addr_xfer", 32'(apb_write_paddr), 32'(5));
    tick();
    check("t6_rsp", 32'(rsp_valid), 32'h1);
    check("t6_addr_done", 32'(apb_write_paddr), 32'(5));
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
